arb_grant_mux: RTL and testbench
================================

ARB_GRANT_MUX -- requirements
Module: arb_grant_mux

Interface
REQ-001 SHALL have parameter DW, default 8, data beat width in bits.
REQ-002 SHALL have parameter CW, default 16, grant-statistics counter width in bits.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port gnt  input  3  one-hot grant from the upstream 3-master round-robin arbiter (bit i = master i).
REQ-006 SHALL have port m_valid  input  3  per-master beat valid.
REQ-007 SHALL have port m_data  input  3*DW  per-master data, master i at bits [i*DW +: DW].
REQ-008 SHALL have port m_last  input  3  per-master last beat of burst.
REQ-009 SHALL have port m_ready  output  3  per-master beat accept.
REQ-010 SHALL have port s_valid  output  1  slave-side beat valid.
REQ-011 SHALL have port s_data  output  DW  slave-side data.
REQ-012 SHALL have port s_last  output  1  slave-side last beat.
REQ-013 SHALL have port s_src  output  2  index (0..2) of master owning current s_data.
REQ-014 SHALL have port s_ready  input  1  slave accept.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port err_multi  output  1  sticky: gnt seen with more than one bit set.
REQ-017 SHALL have port err_abort  output  1  sticky: owner grant dropped before its last beat.
REQ-018 SHALL have port stat_cnt  output  3*CW  per-master grant counts, master i at [i*CW +: CW] (present only with GNT_STATS_EN).

Function
REQ-019 SHALL implement FSM states IDLE, OWN, DRAIN.
REQ-020 IDLE: exactly one gnt bit set -> latch owner index, go OWN next cycle; zero bits -> stay; 2+ bits -> set err_multi, stay IDLE, no owner latched.
REQ-021 OWN: m_ready[owner] = gnt[owner] & (~s_valid | s_ready); m_ready of non-owners SHALL be 0 in every state.
REQ-022 Beat transfer (m_valid[owner] & m_ready[owner]) SHALL load output register; s_valid/s_data/s_last/s_src valid one cycle later (latency 1).
REQ-023 Output register SHALL hold s_valid/s_data/s_last/s_src stable while s_valid & ~s_ready; back-to-back beats at full throughput when s_ready held high.
REQ-024 OWN -> DRAIN on transfer with m_last[owner]=1.
REQ-025 OWN with gnt[owner]=0 (drop or switch to other master) and no transfer that cycle: set err_abort, go DRAIN; no beat accepted from new master until IDLE.
REQ-026 DRAIN -> IDLE when output register empty or emptying (~s_valid | s_ready); IDLE re-evaluates gnt same cycle it is entered? no -- one cycle later.
REQ-027 gnt multi-hot while OWN: set err_multi; behaviour otherwise per REQ-025 using gnt[owner].
REQ-028 Sticky errors SHALL clear only on rst.

Reset
REQ-029 On rst: state IDLE, s_valid=0, s_data=0, s_last=0, s_src=0, m_ready=0, busy=0, err_multi=0, err_abort=0, stat_cnt=0.
REQ-030 rst mid-burst SHALL discard any beat in the output register; no s_valid pulse after rst deasserts until a new grant.

Configuration
REQ-031 Macro GNT_STATS_EN defined: stat_cnt present; counter[owner] increments by 1 on each IDLE->OWN transition, saturating at 2^CW-1.
REQ-032 GNT_STATS_EN undefined: stat_cnt port and counters absent; all other behaviour identical.

Structure
REQ-033 Shared package arb_pkg SHALL hold FSM state enum (IDLE/OWN/DRAIN), NUM_MASTERS=3, and master-index typedef (2 bits).
REQ-034 Sub-module arb_out_reg SHALL implement the 1-entry valid/ready output register (REQ-022/023).

Verification
REQ-035 gnt=001, master0 sends 3 beats 0xA1,0xA2,0xA3(last), s_ready=1 -> s_data A1,A2,A3 on consecutive cycles, s_src=0, s_last on A3, busy falls after DRAIN.
REQ-036 gnt=100, beat 0x55 last, s_ready=0 for 4 cycles -> s_valid/s_data=0x55/s_src=2 held stable 4 cycles, m_ready[2]=0 meanwhile, completes when s_ready=1.
REQ-037 gnt=011 in IDLE -> err_multi=1, m_ready=000, busy=0; stays 1 until rst.
REQ-038 gnt=010, one non-last beat accepted, gnt->000 -> err_abort=1, state DRAIN then IDLE, no further master1 beats accepted.
REQ-039 rst asserted with beat pending (s_valid=1,s_ready=0) -> next cycle all outputs 0, state IDLE.
REQ-040 GNT_STATS_EN, 3 bursts master1 then 1 master0 -> stat_cnt fields {0,3,1}; CW=2 with 5 master1 bursts -> field1 saturates at 3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the grant mux: FSM states, master count and master index.
// No logic, no latency, no flow control of its own.
// Imported by the interface and the top-level mux.
package arb_pkg;

    localparam int NUM_MASTERS = 3;

    typedef logic [1:0] midx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    function automatic logic gnt_is_multi(input logic [NUM_MASTERS-1:0] g);
        return |(g & (g - NUM_MASTERS'(1)));
    endfunction

    function automatic midx_t gnt_to_idx(input logic [NUM_MASTERS-1:0] g);
        midx_t idx;
        idx = 2'd0;
        if (g[2])      idx = 2'd2;
        else if (g[1]) idx = 2'd1;
        return idx;
    endfunction

endpackage

// File: rtl/arb_grant_mux_if.sv
// Bus bundle between the upstream masters/arbiter and the mux, plus the slave side.
// Pure wiring; latency and backpressure are defined by the module using it.
// slave modport is the mux's view, master modport is the environment's view.
interface arb_grant_mux_if #(
    parameter int DW = 8
);
    import arb_pkg::*;

    logic [NUM_MASTERS-1:0]    gnt;
    logic [NUM_MASTERS-1:0]    m_valid;
    logic [NUM_MASTERS*DW-1:0] m_data;
    logic [NUM_MASTERS-1:0]    m_last;
    logic [NUM_MASTERS-1:0]    m_ready;
    logic                      s_valid;
    logic [DW-1:0]             s_data;
    logic                      s_last;
    midx_t                     s_src;
    logic                      s_ready;

    modport slave (
        input  gnt, m_valid, m_data, m_last, s_ready,
        output m_ready, s_valid, s_data, s_last, s_src
    );

    modport master (
        output gnt, m_valid, m_data, m_last, s_ready,
        input  m_ready, s_valid, s_data, s_last, s_src
    );

endinterface

// File: rtl/arb_out_reg.sv
// One-entry valid/ready register stage.
// Latency 1 cycle; full throughput when out_rdy stays high.
// Holds out_dat stable while out_vld & ~out_rdy; in_rdy drops only when full and stalled.
module arb_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    assign in_rdy = ~out_vld | out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/arb_grant_mux.sv
// Steers the granted master's burst onto a single slave port; optional per-master grant counters (GNT_STATS_EN).
// Latency 1 cycle from master beat accept to s_valid; back-to-back beats at full rate.
// Only the latched owner sees m_ready, and only while the output register can take a beat.
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    arb_grant_mux_if.slave            bus,
    output logic                      busy,
    output logic                      err_multi,
    output logic                      err_abort
`ifdef GNT_STATS_EN
    ,
    output logic [NUM_MASTERS*CW-1:0] stat_cnt
`endif
);

    state_t        state;
    midx_t         owner;

    logic          gnt_multi;
    logic          gnt_one;
    midx_t         gnt_idx;
    logic          own_gnt;
    logic          own_vld;
    logic          own_last;
    logic [DW-1:0] own_dat;
    logic          oreg_rdy;
    logic          xfer;
    logic          grant_taken;
    logic [DW+2:0] oreg_dat;

    assign gnt_multi   = gnt_is_multi(bus.gnt);
    assign gnt_one     = (bus.gnt != '0) && !gnt_multi;
    assign gnt_idx     = gnt_to_idx(bus.gnt);
    assign grant_taken = (state == IDLE) && gnt_one;

    assign own_gnt  = bus.gnt[owner];
    assign own_vld  = bus.m_valid[owner];
    assign own_last = bus.m_last[owner];
    assign own_dat  = bus.m_data[owner*DW +: DW];

    assign xfer = (state == OWN) && own_gnt && own_vld && oreg_rdy;
    assign busy = (state != IDLE);

    always_comb begin
        bus.m_ready = '0;
        if (state == OWN) begin
            bus.m_ready[owner] = own_gnt & oreg_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            err_multi <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            if (gnt_multi) begin
                err_multi <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gnt_one) begin
                        owner <= gnt_idx;
                        state <= OWN;
                    end
                end
                OWN: begin
                    // A lost grant only aborts if the owner did not finish its burst this cycle.
                    if (xfer && own_last) begin
                        state <= DRAIN;
                    end else if (!own_gnt) begin
                        err_abort <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.s_valid || bus.s_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_out_reg #(
        .W (DW + 3)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (xfer),
        .in_rdy  (oreg_rdy),
        .in_dat  ({own_last, owner, own_dat}),
        .out_vld (bus.s_valid),
        .out_rdy (bus.s_ready),
        .out_dat (oreg_dat)
    );

    assign bus.s_last = oreg_dat[DW+2];
    assign bus.s_src  = oreg_dat[DW+1:DW];
    assign bus.s_data = oreg_dat[DW-1:0];

`ifdef GNT_STATS_EN
    logic [CW-1:0] cnt [NUM_MASTERS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                cnt[i] <= '0;
            end
        end else if (grant_taken && (cnt[gnt_idx] != '1)) begin
            cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stat
        assign stat_cnt[g*CW +: CW] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_arb_grant_mux.sv
// Scoreboarded bench for arb_grant_mux: directed scenarios plus randomized bursts.
// Stats checks run only when GNT_STATS_EN is defined (counters sized CW=2 to reach saturation).
module tb_arb_grant_mux;
    localparam int DW = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    s;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic busy, err_multi, err_abort;
`ifdef GNT_STATS_EN
    logic [3*CW-1:0] stat_cnt;
`endif

    always #5 clk = ~clk;

    arb_grant_mux_if #(.DW(DW)) bus ();

    arb_grant_mux #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .err_multi (err_multi),
        .err_abort (err_abort)
`ifdef GNT_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    int    checks = 0;
    int    fails  = 0;
    beat_t exp_q[$];
    logic [2:0] owner_mask = 3'b000;
    int    sc[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Saturating grant counter model.
    function automatic void grant_model(input int m);
        if (sc[m] < (1 << CW) - 1) sc[m] = sc[m] + 1;
    endfunction

    task automatic chk_stats();
`ifdef GNT_STATS_EN
        logic [3*CW-1:0] e;
        for (int i = 0; i < 3; i++) e[i*CW +: CW] = CW'(sc[i]);
        chk("stat_cnt", stat_cnt, e);
`endif
    endtask

    // Monitor: pops the scoreboard on every slave handshake, checks hold and ready isolation.
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", {bus.s_valid, bus.s_data, bus.s_last, bus.s_src}, {1'b1, prev_beat});
            chk("nonowner_ready", bus.m_ready & ~owner_mask, 0);
            if (bus.s_valid && bus.s_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h src %0d, expected no beat", bus.s_data, bus.s_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {bus.s_data, bus.s_last, bus.s_src}, e);
                end
            end
            prev_stall = bus.s_valid && !bus.s_ready;
            prev_beat  = {bus.s_data, bus.s_last, bus.s_src};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.gnt = '0; bus.m_valid = '0; bus.m_last = '0; bus.m_data = '0; bus.s_ready = 1'b0;
        exp_q.delete();
        owner_mask = 3'b000;
        for (int i = 0; i < 3; i++) sc[i] = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk("idle_after_burst", done, 1);
        tick();
    endtask

    task automatic burst(input int m, input int len, input bit rnd,
                         input logic [4*DW-1:0] dv, output int ncyc);
        int    b;
        logic  acc;
        beat_t e;
        for (int k = 0; k < len; k++) begin
            e.d = dv[k*DW +: DW];
            e.l = (k == len - 1);
            e.s = 2'(m);
            exp_q.push_back(e);
        end
        bus.gnt = 3'(1 << m);
        owner_mask = 3'(1 << m);
        grant_model(m);
        bus.m_valid[m] = 1'b1;
        bus.m_data[m*DW +: DW] = dv[DW-1:0];
        bus.m_last[m] = (len == 1);
        b = 0;
        ncyc = 0;
        while (b < len && ncyc < 200) begin
            @(negedge clk);
            acc = bus.m_valid[m] & bus.m_ready[m];
            tick();
            ncyc++;
            if (rnd) bus.s_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                b++;
                if (b < len) begin
                    bus.m_data[m*DW +: DW] = dv[b*DW +: DW];
                    bus.m_last[m] = (b == len - 1);
                end else begin
                    bus.m_valid[m] = 1'b0;
                    bus.m_last[m] = 1'b0;
                    bus.gnt = '0;
                end
            end
        end
        if (b < len) begin
            checks++;
            fails++;
            $display("FAIL burst_timeout: master %0d got %0d beats, expected %0d", m, b, len);
            bus.m_valid[m] = 1'b0;
            bus.gnt = '0;
        end
        bus.s_ready = 1'b1;
        wait_idle();
        owner_mask = 3'b000;
    endtask

    initial begin
        int nc;
        rst = 1'b1;
        bus.gnt = '0; bus.m_valid = '0; bus.m_last = '0; bus.m_data = '0; bus.s_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset_outputs", {bus.s_valid, bus.s_data, bus.s_last, bus.s_src, bus.m_ready,
                              busy, err_multi, err_abort}, 0);
        chk_stats();
        tick();

        // Three-beat burst from master 0 at full rate.
        bus.s_ready = 1'b1;
        burst(0, 3, 1'b0, 32'h00A3A2A1, nc);
        chk("m0_burst_cycles", nc, 4);
        chk("m0_flags", {busy, err_multi, err_abort}, 0);

        // Single last beat from master 2 under slave backpressure.
        bus.s_ready = 1'b0;
        bus.gnt = 3'b100; owner_mask = 3'b100; grant_model(2);
        bus.m_valid[2] = 1'b1; bus.m_data[2*DW +: DW] = 8'h55; bus.m_last[2] = 1'b1;
        exp_q.push_back('{d: 8'h55, l: 1'b1, s: 2'd2});
        tick();
        tick();
        bus.m_data[2*DW +: DW] = 8'h66; bus.m_last[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_s_valid", bus.s_valid, 1);
            chk("stall_s_data", bus.s_data, 8'h55);
            chk("stall_s_src", bus.s_src, 2);
            chk("stall_m_ready", bus.m_ready, 0);
            tick();
        end
        bus.gnt = '0; bus.m_valid = '0; bus.s_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_done_busy", busy, 0);
        tick();
        owner_mask = 3'b000;

        // Multi-hot grant in IDLE.
        bus.gnt = 3'b011;
        tick();
        @(negedge clk);
        chk("multi_err", err_multi, 1);
        chk("multi_m_ready", bus.m_ready, 0);
        chk("multi_busy", busy, 0);
        tick();
        bus.gnt = '0;
        tick();
        tick();
        @(negedge clk);
        chk("multi_sticky", err_multi, 1);
        do_reset();
        @(negedge clk);
        chk("multi_cleared", err_multi, 0);
        tick();

        // Grant withdrawn mid-burst from master 1.
        bus.s_ready = 1'b1;
        bus.gnt = 3'b010; owner_mask = 3'b010; grant_model(1);
        bus.m_valid[1] = 1'b1; bus.m_data[1*DW +: DW] = 8'h77; bus.m_last[1] = 1'b0;
        exp_q.push_back('{d: 8'h77, l: 1'b0, s: 2'd1});
        tick();
        tick();
        bus.gnt = '0; bus.m_data[1*DW +: DW] = 8'h78;
        @(negedge clk);
        chk("abort_m_ready_dropped", bus.m_ready, 0);
        tick();
        bus.gnt = 3'b010;
        @(negedge clk);
        chk("abort_err", err_abort, 1);
        chk("abort_drain_busy", busy, 1);
        chk("abort_drain_m_ready", bus.m_ready, 0);
        tick();
        bus.gnt = '0; bus.m_valid = '0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_sticky", err_abort, 1);
        tick();
        owner_mask = 3'b000;

        // Reset while a beat is stuck in the output register.
        bus.s_ready = 1'b0;
        bus.gnt = 3'b001; owner_mask = 3'b001;
        bus.m_valid[0] = 1'b1; bus.m_data[0 +: DW] = 8'h99; bus.m_last[0] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("pending_before_rst", bus.s_valid, 1);
        tick();
        do_reset();
        @(negedge clk);
        chk("rst_mid_outputs", {bus.s_valid, bus.s_data, bus.s_last, bus.s_src, bus.m_ready,
                                busy, err_multi, err_abort}, 0);
        chk_stats();
        tick();
        bus.s_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("rst_no_ghost", bus.s_valid, 0);
        tick();

`ifdef GNT_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) burst(1, 1 + i, 1'b0, 32'($urandom), nc);
        burst(0, 2, 1'b0, 32'($urandom), nc);
        chk("stats_031", stat_cnt, {2'd0, 2'd3, 2'd1});
        for (int i = 0; i < 5; i++) burst(1, 1, 1'b0, 32'($urandom), nc);
        chk("stats_saturate", stat_cnt, {2'd0, 2'd3, 2'd1});
`endif

        // Randomized bursts with random slave backpressure.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            burst($urandom_range(0, 2), $urandom_range(1, 4), 1'b1, 32'($urandom), nc);
            chk("rand_err_flags", {err_multi, err_abort}, 0);
            chk_stats();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
